// File: rtl/ahb_slave_mux_pkg.sv
// Shared AHB encodings for the slave-side multiplexer: transfer types,
// burst types, response codes, mux FSM states and the fixed-burst beat limit.
package AHB_package;

   typedef enum logic [1:0] {
      IDLE   = 2'b00,
      BUSY   = 2'b01,
      NONSEQ = 2'b10,
      SEQ    = 2'b11
   } htrans_type;

   typedef enum logic [2:0] {
      SINGLE = 3'd0,
      INCR   = 3'd1,
      WRAP4  = 3'd2,
      INCR4  = 3'd3,
      WRAP8  = 3'd4,
      INCR8  = 3'd5,
      WRAP16 = 3'd6,
      INCR16 = 3'd7
   } hburst_type;

   localparam logic HRESP_OKAY  = 1'b0;
   localparam logic HRESP_ERROR = 1'b1;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_DATA = 2'd1,
      S_WAIT = 2'd2,
      S_ERR  = 2'd3
   } mux_state_e;

   // Index of the last beat of a fixed-length burst; 0 means unbounded.
   function automatic logic [3:0] beat_limit(input hburst_type b);
      case (b)
         WRAP4,  INCR4:  return 4'd3;
         WRAP8,  INCR8:  return 4'd7;
         WRAP16, INCR16: return 4'd15;
         default:        return 4'd0;
      endcase
   endfunction

endpackage

// File: rtl/ahb_slave_mux_onehot_mux.sv
// One-hot select mux: outputs the selected input, zero for an empty or
// multi-hot select, and flags the multi-hot case.
module AHB_onehot_mux #(
   parameter int W = 8,
   parameter int N = 2
) (
   input  logic [N-1:0] sel_i,
   input  logic [W-1:0] din_i [N],
   output logic [W-1:0] dout_o,
   output logic         multi_o
);

   logic         onehot;
   logic [W-1:0] acc;

   always_comb begin
      onehot  = (sel_i != '0) && ((sel_i & (sel_i - N'(1))) == '0);
      multi_o = (sel_i != '0) && !onehot;
      acc     = '0;
      for (int i = 0; i < N; i++) begin
         if (sel_i[i]) acc = acc | din_i[i];
      end
      dout_o = onehot ? acc : '0;
   end

endmodule

// File: rtl/ahb_slave_mux.sv
// Slave-side AHB mux: routes the granted master's address phase, tracks the
// data-phase owner for write data and responses, and flags protocol errors.
module ahb_slave_mux
   import AHB_package::*;
#(
   parameter int MASTER_NUM = 2,
   parameter int ADDR_W     = 32,
   parameter int DATA_W     = 32
) (
   input  logic                  hclk,
   input  logic                  hreset,
   input  logic [MASTER_NUM-1:0] hgrant,
   input  logic [ADDR_W-1:0]     haddr_m  [MASTER_NUM],
   input  logic [1:0]            htrans_m [MASTER_NUM],
   input  logic                  hwrite_m [MASTER_NUM],
   input  logic [2:0]            hsize_m  [MASTER_NUM],
   input  hburst_type            hburst_m [MASTER_NUM],
   input  logic [DATA_W-1:0]     hwdata_m [MASTER_NUM],
   input  logic                  hreadyout_s,
   input  logic                  hresp_s,
   input  logic [DATA_W-1:0]     hrdata_s,
   output logic [ADDR_W-1:0]     haddr_s,
   output logic [1:0]            htrans_s,
   output logic                  hwrite_s,
   output logic [2:0]            hsize_s,
   output hburst_type            hburst_s,
   output logic [DATA_W-1:0]     hwdata_s,
   output logic [MASTER_NUM-1:0] hready_m,
   output logic [MASTER_NUM-1:0] hresp_m,
   output logic [DATA_W-1:0]     hrdata_m,
   output logic                  hwait,
   output logic                  grant_err,
   output logic                  burst_err,
   output mux_state_e            state_o,
   output logic [MASTER_NUM-1:0] dp_own_o,
   output logic [3:0]            beat_cnt_o
);

   localparam int CTRL_W = ADDR_W + 9;

   logic [CTRL_W-1:0]     ctrl_in [MASTER_NUM];
   logic [CTRL_W-1:0]     ctrl_out;
   logic                  addr_multi, wdata_multi;
   mux_state_e            state_q;
   logic [MASTER_NUM-1:0] dp_own_q, dp_own_d;
   logic [3:0]            cnt_q, cnt_d, limit;
   hburst_type            burst_q, burst_d;
   logic                  err_seen_q, err_seen_d;
   logic                  grant_err_q, burst_err_q;
   logic                  accepted, ends_burst, err_now, abort;

   always_comb begin
      for (int i = 0; i < MASTER_NUM; i++) begin
         ctrl_in[i] = {haddr_m[i], htrans_m[i], hwrite_m[i], hsize_m[i], hburst_m[i]};
      end
   end

   AHB_onehot_mux #(.W(CTRL_W), .N(MASTER_NUM)) u_addr_mux (
      .sel_i  (hgrant),
      .din_i  (ctrl_in),
      .dout_o (ctrl_out),
      .multi_o(addr_multi)
   );

   AHB_onehot_mux #(.W(DATA_W), .N(MASTER_NUM)) u_wdata_mux (
      .sel_i  (dp_own_q),
      .din_i  (hwdata_m),
      .dout_o (hwdata_s),
      .multi_o(wdata_multi)
   );

   // An all-zero mux output decodes as IDLE / SINGLE, so no extra forcing is needed.
   assign haddr_s  = ctrl_out[CTRL_W-1 -: ADDR_W];
   assign htrans_s = ctrl_out[8:7];
   assign hwrite_s = ctrl_out[6];
   assign hsize_s  = ctrl_out[5:3];
   assign hburst_s = hburst_type'(ctrl_out[2:0]);

   assign hrdata_m   = hrdata_s;
   assign hwait      = (state_q != S_IDLE) && !hreadyout_s;
   assign grant_err  = grant_err_q;
   assign burst_err  = burst_err_q;
   assign state_o    = state_q;
   assign dp_own_o   = dp_own_q;
   assign beat_cnt_o = cnt_q;

   always_comb begin
      hready_m = '1;
      hresp_m  = '0;
      for (int i = 0; i < MASTER_NUM; i++) begin
         hready_m[i] = dp_own_q[i] ? hreadyout_s : 1'b1;
         hresp_m[i]  = dp_own_q[i] ? hresp_s : HRESP_OKAY;
      end
   end

   always_comb begin
      accepted   = hreadyout_s && (htrans_s == NONSEQ || htrans_s == SEQ);
      ends_burst = hreadyout_s && (htrans_s == IDLE || htrans_s == NONSEQ);
      err_now    = (state_q != S_IDLE) && (hresp_s == HRESP_ERROR);
      limit      = beat_limit(burst_q);
      // A fixed burst that already took an ERROR may legally be cut short.
      abort      = ends_burst && (limit != 4'd0) && (cnt_q < limit) && !(err_seen_q || err_now);

      dp_own_d   = dp_own_q;
      if (hreadyout_s) dp_own_d = accepted ? hgrant : '0;

      cnt_d      = cnt_q;
      burst_d    = burst_q;
      err_seen_d = err_seen_q || err_now;
      if (accepted && htrans_s == NONSEQ) begin
         cnt_d      = 4'd0;
         burst_d    = hburst_s;
         err_seen_d = 1'b0;
      end else if (accepted && (limit == 4'd0 || cnt_q < limit)) begin
         // Fixed bursts saturate at their last beat; unbounded ones wrap mod 16.
         cnt_d = cnt_q + 4'd1;
      end
   end

   always_ff @(posedge hclk) begin
      if (hreset) begin
         state_q     <= S_IDLE;
         dp_own_q    <= '0;
         cnt_q       <= 4'd0;
         burst_q     <= SINGLE;
         err_seen_q  <= 1'b0;
         grant_err_q <= 1'b0;
         burst_err_q <= 1'b0;
      end else begin
         dp_own_q   <= dp_own_d;
         cnt_q      <= cnt_d;
         burst_q    <= burst_d;
         err_seen_q <= err_seen_d;
         if (addr_multi || wdata_multi) grant_err_q <= 1'b1;
         if (abort) burst_err_q <= 1'b1;
         case (state_q)
            S_IDLE: if (accepted) state_q <= S_DATA;
            S_DATA, S_WAIT: begin
               if (!hreadyout_s) state_q <= (hresp_s == HRESP_ERROR) ? S_ERR : S_WAIT;
               else              state_q <= accepted ? S_DATA : S_IDLE;
            end
            S_ERR: if (hreadyout_s) state_q <= accepted ? S_DATA : S_IDLE;
            default: state_q <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ahb_slave_mux.sv
// Randomised and directed stimulus for ahb_slave_mux, checked against a
// transaction-level reference model through an expected-response queue.
module tb_ahb_slave_mux;
   import AHB_package::*;

   localparam int MN = 2;
   localparam int AW = 32;
   localparam int DW = 32;

   // clock / reset
   logic hclk = 1'b0;
   logic hreset;
   always #5 hclk = ~hclk;

   logic [MN-1:0] hgrant;
   logic [AW-1:0] haddr_m  [MN];
   logic [1:0]    htrans_m [MN];
   logic          hwrite_m [MN];
   logic [2:0]    hsize_m  [MN];
   hburst_type    hburst_m [MN];
   logic [DW-1:0] hwdata_m [MN];
   logic          hreadyout_s, hresp_s;
   logic [DW-1:0] hrdata_s;
   logic [AW-1:0] haddr_s;
   logic [1:0]    htrans_s;
   logic          hwrite_s;
   logic [2:0]    hsize_s;
   hburst_type    hburst_s;
   logic [DW-1:0] hwdata_s;
   logic [MN-1:0] hready_m, hresp_m;
   logic [DW-1:0] hrdata_m;
   logic          hwait, grant_err, burst_err;
   mux_state_e    state_o;
   logic [MN-1:0] dp_own_o;
   logic [3:0]    beat_cnt_o;

   ahb_slave_mux #(.MASTER_NUM(MN), .ADDR_W(AW), .DATA_W(DW)) dut (
      .hclk(hclk), .hreset(hreset), .hgrant(hgrant),
      .haddr_m(haddr_m), .htrans_m(htrans_m), .hwrite_m(hwrite_m),
      .hsize_m(hsize_m), .hburst_m(hburst_m), .hwdata_m(hwdata_m),
      .hreadyout_s(hreadyout_s), .hresp_s(hresp_s), .hrdata_s(hrdata_s),
      .haddr_s(haddr_s), .htrans_s(htrans_s), .hwrite_s(hwrite_s),
      .hsize_s(hsize_s), .hburst_s(hburst_s), .hwdata_s(hwdata_s),
      .hready_m(hready_m), .hresp_m(hresp_m), .hrdata_m(hrdata_m),
      .hwait(hwait), .grant_err(grant_err), .burst_err(burst_err),
      .state_o(state_o), .dp_own_o(dp_own_o), .beat_cnt_o(beat_cnt_o)
   );

   typedef struct packed {
      logic [AW-1:0] haddr;
      logic [1:0]    htrans;
      logic          hwrite;
      logic [2:0]    hsize;
      logic [2:0]    hburst;
      logic [DW-1:0] hwdata;
      logic [MN-1:0] hready;
      logic [MN-1:0] hresp;
      logic [DW-1:0] hrdata;
      logic          hwait;
      logic          gerr;
      logic          berr;
      logic [MN-1:0] dp_own;
      logic [1:0]    state;
      logic [3:0]    cnt;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;
   int   compared   = 0;
   int   mismatched = 0;

   // reference model: who owns the data phase, how many beats a fixed burst still owes
   int owner      = -1;
   bit gerr_m     = 0;
   bit berr_m     = 0;
   int beats_left = 0;
   bit burst_errd = 0;
   bit stalled    = 0;
   bit stall_err  = 0;
   int seq_cnt    = 0;
   int cur_len    = 0;

   function automatic int granted();
      if ($countones(hgrant) != 1) return -1;
      for (int i = 0; i < MN; i++) if (hgrant[i]) return i;
      return -1;
   endfunction

   function automatic int burst_len(input hburst_type b);
      case (b)
         WRAP4, INCR4:   return 4;
         WRAP8, INCR8:   return 8;
         WRAP16, INCR16: return 16;
         default:        return 0;
      endcase
   endfunction

   task automatic push_expected();
      exp_t e;
      int   g;
      g = granted();
      e = '0;
      if (g >= 0) begin
         e.haddr  = haddr_m[g];
         e.htrans = htrans_m[g];
         e.hwrite = hwrite_m[g];
         e.hsize  = hsize_m[g];
         e.hburst = hburst_m[g];
      end
      e.hwdata = (owner >= 0) ? hwdata_m[owner] : '0;
      for (int i = 0; i < MN; i++) begin
         e.hready[i] = (i == owner) ? hreadyout_s : 1'b1;
         e.hresp[i]  = (i == owner) ? hresp_s : 1'b0;
      end
      e.hrdata = hrdata_s;
      e.hwait  = (owner >= 0) && !hreadyout_s;
      e.gerr   = gerr_m;
      e.berr   = berr_m;
      e.dp_own = (owner >= 0) ? MN'(1 << owner) : '0;
      if (owner < 0)      e.state = S_IDLE;
      else if (!stalled)  e.state = S_DATA;
      else if (stall_err) e.state = S_ERR;
      else                e.state = S_WAIT;
      e.cnt = (cur_len > 0) ? 4'((seq_cnt < cur_len - 1) ? seq_cnt : cur_len - 1) : 4'(seq_cnt % 16);
      exp_q.push_back(e);
   endtask

   task automatic model_update();
      int         g;
      logic [1:0] t;
      bit         data_err;
      if (hreset) begin
         owner = -1; gerr_m = 0; berr_m = 0; beats_left = 0; burst_errd = 0;
         stalled = 0; stall_err = 0; seq_cnt = 0; cur_len = 0;
         return;
      end
      g = granted();
      t = (g >= 0) ? htrans_m[g] : IDLE;
      if ($countones(hgrant) > 1) gerr_m = 1;
      data_err = (owner >= 0) && hresp_s;
      if (hreadyout_s && (t == IDLE || t == NONSEQ) && beats_left > 0 && !(burst_errd || data_err))
         berr_m = 1;
      if (hreadyout_s && t == NONSEQ) begin
         cur_len    = burst_len(hburst_m[g]);
         beats_left = (cur_len > 0) ? cur_len - 1 : 0;
         burst_errd = 0;
         seq_cnt    = 0;
      end else begin
         if (data_err) burst_errd = 1;
         if (hreadyout_s && t == SEQ) begin
            if (beats_left > 0) beats_left--;
            seq_cnt++;
         end
      end
      if (hreadyout_s) begin
         stalled = 0; stall_err = 0;
      end else if (owner >= 0) begin
         stalled = 1; stall_err = stall_err | hresp_s;
      end
      if (hreadyout_s) owner = (t == NONSEQ || t == SEQ) ? g : -1;
   endtask

   // driver tasks
   task automatic step();
      push_expected();
      @(posedge hclk);
      model_update();
      #1;
   endtask

   task automatic set_m(input int m, input logic [1:0] t, input logic [AW-1:0] a,
                        input logic w, input hburst_type b, input logic [DW-1:0] d);
      htrans_m[m] = t; haddr_m[m] = a; hwrite_m[m] = w;
      hsize_m[m]  = 3'd2; hburst_m[m] = b; hwdata_m[m] = d;
   endtask

   task automatic quiet();
      hgrant = '0; hreadyout_s = 1'b1; hresp_s = 1'b0; hrdata_s = '0;
      for (int m = 0; m < MN; m++) set_m(m, IDLE, '0, 1'b0, SINGLE, '0);
   endtask

   task automatic do_reset();
      hreset = 1'b1; step(); step(); hreset = 1'b0;
   endtask

   // scoreboard
   task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
      end
   endtask

   always @(negedge hclk) begin
      if (exp_q.size() != 0) begin
         mon_e = exp_q.pop_front();
         chk("haddr_s",   haddr_s,            mon_e.haddr);
         chk("htrans_s",  32'(htrans_s),      32'(mon_e.htrans));
         chk("hwrite_s",  32'(hwrite_s),      32'(mon_e.hwrite));
         chk("hsize_s",   32'(hsize_s),       32'(mon_e.hsize));
         chk("hburst_s",  32'(hburst_s),      32'(mon_e.hburst));
         chk("hwdata_s",  hwdata_s,           mon_e.hwdata);
         chk("hready_m",  32'(hready_m),      32'(mon_e.hready));
         chk("hresp_m",   32'(hresp_m),       32'(mon_e.hresp));
         chk("hrdata_m",  hrdata_m,           mon_e.hrdata);
         chk("hwait",     32'(hwait),         32'(mon_e.hwait));
         chk("grant_err", 32'(grant_err),     32'(mon_e.gerr));
         chk("burst_err", 32'(burst_err),     32'(mon_e.berr));
         chk("dp_own",    32'(dp_own_o),      32'(mon_e.dp_own));
         chk("state",     32'(state_o),       32'(mon_e.state));
         chk("beat_cnt",  32'(beat_cnt_o),    32'(mon_e.cnt));
      end
   end

   initial begin
      hreset = 1'b1;
      quiet();
      @(posedge hclk);
      #1;
      do_reset();
      step();

      // single write from master 0
      hgrant = 2'b01;
      set_m(0, NONSEQ, 32'h100, 1'b1, SINGLE, '0); step();
      set_m(0, IDLE, 32'h0, 1'b0, SINGLE, 32'hCAFE_0001); step();
      quiet(); step();

      // INCR4 write from master 1 with a two-cycle stall on beat 2
      hgrant = 2'b10;
      set_m(0, NONSEQ, 32'hDEAD_0000, 1'b0, INCR8, 32'h1111_1111);
      set_m(1, NONSEQ, 32'h200, 1'b1, INCR4, '0);           step();
      set_m(1, SEQ, 32'h204, 1'b1, INCR4, 32'hB000_0001);   step();
      set_m(1, SEQ, 32'h208, 1'b1, INCR4, 32'hB000_0002);
      hreadyout_s = 1'b0; step(); step();
      hreadyout_s = 1'b1; step();
      set_m(1, SEQ, 32'h20C, 1'b1, INCR4, 32'hB000_0003);   step();
      set_m(1, IDLE, 32'h0, 1'b0, SINGLE, 32'hB000_0004);   step();
      quiet(); step();

      // WRAP8 from master 0 cut short after three beats
      hgrant = 2'b01;
      set_m(0, NONSEQ, 32'h300, 1'b1, WRAP8, '0);           step();
      set_m(0, SEQ, 32'h304, 1'b1, WRAP8, 32'hA1);          step();
      set_m(0, SEQ, 32'h308, 1'b1, WRAP8, 32'hA2);          step();
      set_m(0, NONSEQ, 32'h400, 1'b0, SINGLE, 32'hA3);      step();
      quiet(); for (int i = 0; i < 4; i++) step();
      do_reset();

      // two-cycle ERROR response to master 0 while master 1 stays idle
      hgrant = 2'b01;
      set_m(0, NONSEQ, 32'h500, 1'b0, INCR4, '0);           step();
      set_m(0, SEQ, 32'h504, 1'b0, INCR4, '0);
      hreadyout_s = 1'b0; hresp_s = 1'b1; hrdata_s = 32'h5555; step();
      set_m(0, IDLE, 32'h0, 1'b0, SINGLE, '0);
      hreadyout_s = 1'b1; hresp_s = 1'b1;                   step();
      quiet(); step(); step();

      // both masters granted at once
      hgrant = 2'b11;
      set_m(0, NONSEQ, 32'h600, 1'b1, SINGLE, '0);
      set_m(1, NONSEQ, 32'h700, 1'b1, SINGLE, '0);          step();
      quiet(); step(); step();
      do_reset();

      // reset while an INCR16 from master 1 is stalled
      hgrant = 2'b10;
      set_m(1, NONSEQ, 32'h800, 1'b1, INCR16, '0);          step();
      for (int b = 1; b < 4; b++) begin
         set_m(1, SEQ, 32'h800 + 32'(4 * b), 1'b1, INCR16, 32'(b)); step();
      end
      hreadyout_s = 1'b0; step();
      hreset = 1'b1; step();
      hreset = 1'b0; quiet(); step(); step();

      // randomised traffic
      for (int c = 0; c < 600; c++) begin
         int r;
         r = $urandom_range(0, 9);
         hgrant = (r < 4) ? 2'b01 : (r < 8) ? 2'b10 : (r == 8) ? 2'b00 : 2'b11;
         for (int m = 0; m < MN; m++) begin
            htrans_m[m] = 2'($urandom_range(0, 3));
            haddr_m[m]  = $urandom;
            hwrite_m[m] = 1'($urandom_range(0, 1));
            hsize_m[m]  = 3'($urandom_range(0, 7));
            hburst_m[m] = hburst_type'($urandom_range(0, 7));
            hwdata_m[m] = $urandom;
         end
         hreadyout_s = ($urandom_range(0, 3) != 0);
         hresp_s     = ($urandom_range(0, 9) == 0);
         hrdata_s    = $urandom;
         hreset      = ($urandom_range(0, 59) == 0);
         step();
      end
      hreset = 1'b0; quiet(); step();

      @(negedge hclk);
      #1;
      compared++;
      if (exp_q.size() != 0) begin
         mismatched++;
         $display("FAIL drain: got %0d pending expected 0", exp_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
